// File: rtl/fir_job_sequencer_if.sv
// AXI-Lite master and stream pass-through signals between the FIR job sequencer
// and its surroundings; master = sequencer side, slave = FIR core / sources / sinks.
interface fir_job_sequencer_if #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
);
    logic                   awvalid, awready;
    logic [pADDR_WIDTH-1:0] awaddr;
    logic                   wvalid, wready;
    logic [pDATA_WIDTH-1:0] wdata;
    logic                   arvalid, arready;
    logic [pADDR_WIDTH-1:0] araddr;
    logic                   rvalid, rready;
    logic [pDATA_WIDTH-1:0] rdata;
    logic                   src_tvalid, src_tready;
    logic [pDATA_WIDTH-1:0] src_tdata;
    logic                   ss_tvalid, ss_tready, ss_tlast;
    logic [pDATA_WIDTH-1:0] ss_tdata;
    logic                   sm_tvalid, sm_tready, sm_tlast;
    logic [pDATA_WIDTH-1:0] sm_tdata;
    logic                   dst_tvalid, dst_tready, dst_tlast;
    logic [pDATA_WIDTH-1:0] dst_tdata;

    modport master (
        output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
               src_tready, ss_tvalid, ss_tdata, ss_tlast,
               sm_tready, dst_tvalid, dst_tdata, dst_tlast,
        input  awready, wready, arready, rvalid, rdata,
               src_tvalid, src_tdata, ss_tready,
               sm_tvalid, sm_tdata, sm_tlast, dst_tready
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
               src_tready, ss_tvalid, ss_tdata, ss_tlast,
               sm_tready, dst_tvalid, dst_tdata, dst_tlast,
        output awready, wready, arready, rvalid, rdata,
               src_tvalid, src_tdata, ss_tready,
               sm_tvalid, sm_tdata, sm_tlast, dst_tready
    );
endinterface

// File: rtl/fir_job_sequencer.sv
// Runs one FIR job: program length + ap_start over AXI-Lite, gate len samples in/out, poll ap_done.
// Optional: define FIR_SEQ_TLAST_CHK_EN to flag sm_tlast disagreeing with the output count.
module fir_job_sequencer #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int pLEN_WIDTH  = 10,
    parameter int pTIMEOUT    = 15,
    parameter int pPOLL_MAX   = 255
) (
    input  logic                  axis_clk,
    input  logic                  axis_rst_n,
    input  logic                  cfg_start,
    input  logic [pLEN_WIDTH-1:0] cfg_len,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    fir_job_sequencer_if.master   bus
);
    localparam int TMO_W  = $clog2(pTIMEOUT + 1);
    localparam int POLL_W = $clog2(pPOLL_MAX + 1);
    localparam logic [TMO_W-1:0]       TMO_MAX   = TMO_W'(pTIMEOUT);
    localparam logic [POLL_W-1:0]      POLL_MAX  = POLL_W'(pPOLL_MAX);
    localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = pADDR_WIDTH'('h00);
    localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'('h10);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_LEN, S_WR_START, S_RUN, S_POLL_AR, S_POLL_R, S_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [pLEN_WIDTH-1:0] len_q, len_d, in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
    logic [POLL_W-1:0]     poll_cnt_q, poll_cnt_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic                  aw_ok_q, aw_ok_d, w_ok_q, w_ok_d;
    logic                  gap_q, gap_d, err_q, err_d;

    logic in_act, out_act, aw_hs, w_hs, ar_hs, r_hs, ss_hs, sm_hs;

    assign in_act  = (in_cnt_q != len_q);
    assign out_act = (out_cnt_q != len_q);
    assign aw_hs   = bus.awvalid & bus.awready;
    assign w_hs    = bus.wvalid & bus.wready;
    assign ar_hs   = bus.arvalid & bus.arready;
    assign r_hs    = bus.rvalid & bus.rready;
    assign ss_hs   = bus.ss_tvalid & bus.ss_tready;
    assign sm_hs   = bus.sm_tvalid & bus.sm_tready;

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            poll_cnt_q <= '0;
            tmo_q      <= '0;
            aw_ok_q    <= 1'b0;
            w_ok_q     <= 1'b0;
            gap_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            in_cnt_q   <= in_cnt_d;
            out_cnt_q  <= out_cnt_d;
            poll_cnt_q <= poll_cnt_d;
            tmo_q      <= tmo_d;
            aw_ok_q    <= aw_ok_d;
            w_ok_q     <= w_ok_d;
            gap_q      <= gap_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        in_cnt_d   = in_cnt_q;
        out_cnt_d  = out_cnt_q;
        poll_cnt_d = poll_cnt_q;
        tmo_d      = '0;
        aw_ok_d    = aw_ok_q;
        w_ok_d     = w_ok_q;
        gap_d      = 1'b0;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    if (cfg_len == '0) begin
                        err_d = 1'b1;
                    end else begin
                        err_d      = 1'b0;
                        len_d      = cfg_len;
                        in_cnt_d   = '0;
                        out_cnt_d  = '0;
                        poll_cnt_d = '0;
                        state_d    = S_WR_LEN;
                    end
                end
            end
            S_WR_LEN, S_WR_START: begin
                // AW and W complete independently; advance once both have been seen
                aw_ok_d = aw_ok_q | aw_hs;
                w_ok_d  = w_ok_q | w_hs;
                if (aw_ok_d && w_ok_d) begin
                    aw_ok_d = 1'b0;
                    w_ok_d  = 1'b0;
                    state_d = (state_q == S_WR_LEN) ? S_WR_START : S_RUN;
                end else if (tmo_q == TMO_MAX) begin
                    aw_ok_d = 1'b0;
                    w_ok_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_RUN: begin
                if (ss_hs) in_cnt_d = in_cnt_q + 1'b1;
                if (sm_hs) out_cnt_d = out_cnt_q + 1'b1;
`ifdef FIR_SEQ_TLAST_CHK_EN
                if (sm_hs && (bus.sm_tlast != (out_cnt_q == len_q - 1'b1))) err_d = 1'b1;
`endif
                if (!in_act && !out_act) state_d = S_POLL_AR;
            end
            S_POLL_AR: begin
                if (ar_hs) begin
                    state_d = S_POLL_R;
                end else if (tmo_q == TMO_MAX) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_POLL_R: begin
                if (r_hs) begin
                    if (bus.rdata[1]) begin
                        state_d = S_DONE;
                    end else begin
                        poll_cnt_d = poll_cnt_q + 1'b1;
                        if (poll_cnt_d == POLL_MAX) begin
                            err_d   = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            gap_d   = 1'b1;
                            state_d = S_POLL_AR;
                        end
                    end
                end else if (tmo_q == TMO_MAX) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.awvalid    = 1'b0;
        bus.awaddr     = '0;
        bus.wvalid     = 1'b0;
        bus.wdata      = '0;
        bus.arvalid    = 1'b0;
        bus.araddr     = ADDR_CTRL;
        bus.rready     = 1'b0;
        bus.src_tready = 1'b0;
        bus.ss_tvalid  = 1'b0;
        bus.ss_tlast   = 1'b0;
        bus.sm_tready  = 1'b0;
        bus.dst_tvalid = 1'b0;
        bus.dst_tlast  = 1'b0;
        case (state_q)
            S_WR_LEN: begin
                bus.awvalid = !aw_ok_q;
                bus.wvalid  = !w_ok_q;
                bus.awaddr  = ADDR_LEN;
                bus.wdata   = {{(pDATA_WIDTH-pLEN_WIDTH){1'b0}}, len_q};
            end
            S_WR_START: begin
                bus.awvalid = !aw_ok_q;
                bus.wvalid  = !w_ok_q;
                bus.awaddr  = ADDR_CTRL;
                bus.wdata   = pDATA_WIDTH'(1);
            end
            S_RUN: begin
                bus.ss_tvalid  = in_act & bus.src_tvalid;
                bus.src_tready = in_act & bus.ss_tready;
                bus.ss_tlast   = in_act & (in_cnt_q == len_q - 1'b1);
                bus.dst_tvalid = out_act & bus.sm_tvalid;
                bus.sm_tready  = out_act & bus.dst_tready;
                bus.dst_tlast  = out_act & (out_cnt_q == len_q - 1'b1);
            end
            S_POLL_AR: bus.arvalid = !gap_q;
            S_POLL_R:  bus.rready  = 1'b1;
            default: ;
        endcase
    end

    assign bus.ss_tdata  = bus.src_tdata;
    assign bus.dst_tdata = bus.sm_tdata;
    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign err  = err_q;
endmodule

// File: tb/tb_fir_job_sequencer.sv
// Scoreboard bench: stimulus queues expected AXI-Lite/stream/done events, a negedge monitor pops and compares.
module tb_fir_job_sequencer;
    localparam int AW = 12, DW = 32, LW = 10, TMO = 15, PMAX = 255;
`ifdef FIR_SEQ_TLAST_CHK_EN
    localparam int TLAST_ERR = 1;
`else
    localparam int TLAST_ERR = 0;
`endif

    logic          axis_clk = 1'b0, axis_rst_n = 1'b0, cfg_start = 1'b0;
    logic [LW-1:0] cfg_len = '0;
    logic          busy, done, err;

    fir_job_sequencer_if #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) bus();

    fir_job_sequencer #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .pLEN_WIDTH(LW),
                        .pTIMEOUT(TMO), .pPOLL_MAX(PMAX)) dut (
        .axis_clk(axis_clk), .axis_rst_n(axis_rst_n), .cfg_start(cfg_start),
        .cfg_len(cfg_len), .busy(busy), .done(done), .err(err), .bus(bus));

    always #5 axis_clk = ~axis_clk;

    int checks = 0, errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input longint act);
        checks++;
        errors++;
        $display("FAIL %s: got 0x%0h with nothing expected", name, act);
    endtask

    // scoreboard queues
    logic [AW-1:0] exp_aw[$], exp_ar[$];
    logic [DW-1:0] exp_w[$];
    logic [DW:0]   exp_ss[$], exp_dst[$];
    logic          exp_done[$];

    // environment configuration, written only by the main process
    int       aw_dly = 0, poll_nd = 0, dst_mode = 0, sm_total = 0, tl_idx = -1, job_seq = 0;
    bit       aw_block = 1'b0;
    bit [3:0] src_gap = 4'b0000;
    bit       mon_en = 1'b0;

    // FIR core / source / sink responders
    int aw_wait, poll_seen, src_idx, sm_idx, cyc, env_seq;
    bit r_pend;
    initial begin
        bus.awready = 0; bus.wready = 0; bus.arready = 0; bus.rvalid = 0; bus.rdata = '0;
        bus.src_tvalid = 0; bus.src_tdata = '0; bus.ss_tready = 0;
        bus.sm_tvalid = 0; bus.sm_tdata = '0; bus.sm_tlast = 0; bus.dst_tready = 0;
        aw_wait = 0; poll_seen = 0; src_idx = 0; sm_idx = 0; cyc = 0; env_seq = 0; r_pend = 0;
        forever begin
            @(negedge axis_clk);
            if (env_seq != job_seq) begin
                env_seq = job_seq;
                aw_wait = 0; poll_seen = 0; src_idx = 0; sm_idx = 0; r_pend = 0;
            end else begin
                if (bus.awvalid && !bus.awready) aw_wait++; else aw_wait = 0;
                if (bus.rvalid && bus.rready) r_pend = 0;
                if (bus.arvalid && bus.arready) begin poll_seen++; r_pend = 1; end
                if (bus.ss_tvalid && bus.ss_tready) src_idx++;
                if (bus.sm_tvalid && bus.sm_tready) sm_idx++;
            end
            @(posedge axis_clk);
            #1;
            cyc++;
            bus.awready    = !aw_block && (aw_wait >= aw_dly);
            bus.wready     = 1'b1;
            bus.arready    = 1'b1;
            bus.rvalid     = r_pend;
            bus.rdata      = (poll_seen > poll_nd) ? DW'(2) : DW'(0);
            bus.src_tvalid = !src_gap[cyc % 4];
            bus.src_tdata  = DW'('hA000 + src_idx);
            bus.ss_tready  = 1'b1;
            bus.sm_tvalid  = (sm_idx < sm_total);
            bus.sm_tdata   = DW'('h5000 + 3 * sm_idx);
            bus.sm_tlast   = (sm_idx == tl_idx);
            bus.dst_tready = (dst_mode == 0) ? 1'b1 : (dst_mode == 1) ? cyc[0] : 1'b0;
        end
    end

    // monitor
    int aw_hi, w_hi, ar_hi, done_n, mon_seq = 0;
    always @(negedge axis_clk) begin
        if (mon_seq != job_seq) begin
            mon_seq = job_seq; aw_hi = 0; w_hi = 0; ar_hi = 0; done_n = 0;
        end
        if (mon_en) begin
            if (bus.awvalid) aw_hi++;
            if (bus.wvalid)  w_hi++;
            if (bus.arvalid) ar_hi++;
            if (bus.src_tready) chk("src_tready_gate", longint'(exp_ss.size() > 0), 1);
            if (bus.sm_tready)  chk("sm_tready_gate", longint'(exp_dst.size() > 0), 1);
            if (bus.awvalid && bus.awready) begin
                if (exp_aw.size() == 0) fail_now("aw_extra", bus.awaddr);
                else chk("aw_addr", bus.awaddr, exp_aw.pop_front());
            end
            if (bus.wvalid && bus.wready) begin
                if (exp_w.size() == 0) fail_now("w_extra", bus.wdata);
                else chk("w_data", bus.wdata, exp_w.pop_front());
            end
            if (bus.arvalid && bus.arready) begin
                if (exp_ar.size() == 0) fail_now("ar_extra", bus.araddr);
                else chk("ar_addr", bus.araddr, exp_ar.pop_front());
            end
            if (bus.ss_tvalid && bus.ss_tready) begin
                if (exp_ss.size() == 0) fail_now("ss_extra", {bus.ss_tlast, bus.ss_tdata});
                else chk("ss_beat", {bus.ss_tlast, bus.ss_tdata}, exp_ss.pop_front());
            end
            if (bus.dst_tvalid && bus.dst_tready) begin
                if (exp_dst.size() == 0) fail_now("dst_extra", {bus.dst_tlast, bus.dst_tdata});
                else chk("dst_beat", {bus.dst_tlast, bus.dst_tdata}, exp_dst.pop_front());
            end
            if (done) begin
                done_n++;
                if (exp_done.size() == 0) fail_now("done_extra", err);
                else chk("done_err", err, exp_done.pop_front());
            end
        end
    end

    function automatic logic [12:0] ctl_vec();
        return {busy, done, err, bus.awvalid, bus.wvalid, bus.arvalid, bus.rready,
                bus.src_tready, bus.ss_tvalid, bus.ss_tlast, bus.sm_tready,
                bus.dst_tvalid, bus.dst_tlast};
    endfunction

    task automatic new_job(input int len);
        @(negedge axis_clk);
        #1;
        job_seq++;
        sm_total = len + 2;
        tl_idx   = len - 1;
    endtask

    task automatic expect_job(input int len, input int nd, input bit exp_err);
        exp_aw.push_back(AW'('h10)); exp_aw.push_back(AW'('h00));
        exp_w.push_back(DW'(len));   exp_w.push_back(DW'(1));
        for (int i = 0; i < len; i++) begin
            exp_ss.push_back({i == len - 1, DW'('hA000 + i)});
            exp_dst.push_back({i == len - 1, DW'('h5000 + 3 * i)});
        end
        for (int i = 0; i <= nd; i++) exp_ar.push_back(AW'(0));
        exp_done.push_back(exp_err);
    endtask

    task automatic pulse_start(input int len);
        @(posedge axis_clk);
        #1;
        cfg_start = 1'b1;
        cfg_len   = LW'(len);
        @(posedge axis_clk);
        #1;
        cfg_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int i = 0;
        @(negedge axis_clk);
        while (!done && i < budget) begin
            @(negedge axis_clk);
            i++;
        end
        if (!done) begin
            fail_now({tag, "_no_done"}, i);
            return;
        end
        @(negedge axis_clk);
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_busy_after"}, busy, 0);
    endtask

    initial begin
        // reset state, checked while reset is still asserted
        @(posedge axis_clk);
        #2;
        chk("rst_ctl", ctl_vec(), 0);
        chk("rst_addr", {bus.awaddr, bus.araddr}, 0);
        chk("rst_wdata", bus.wdata, 0);
        @(negedge axis_clk);
        axis_rst_n = 1'b1;
        mon_en = 1'b1;

        // 64-sample job, everything ready, ap_done on first poll
        new_job(64);
        expect_job(64, 0, 1'b0);
        pulse_start(64);
        @(negedge axis_clk);
        chk("t1_awvalid_lat", bus.awvalid, 1);
        chk("t1_busy", busy, 1);
        wait_done("t1", 400);
        chk("t1_ar_cycles", ar_hi, 1);
        chk("t1_err", err, 0);

        // awready delayed: AW holds 3 cycles per write, W only 1; two not-done polls
        aw_dly  = 2;
        poll_nd = 2;
        new_job(4);
        expect_job(4, 2, 1'b0);
        pulse_start(4);
        wait_done("t2", 200);
        chk("t2_aw_cycles", aw_hi, 6);
        chk("t2_w_cycles", w_hi, 2);
        chk("t2_ar_cycles", ar_hi, 3);
        aw_dly  = 0;
        poll_nd = 0;

        // awready stuck low: timeout after pTIMEOUT+1 cycles in WR_LEN
        aw_block = 1'b1;
        new_job(4);
        exp_w.push_back(DW'(4));
        exp_done.push_back(1'b1);
        pulse_start(4);
        wait_done("t3", 100);
        chk("t3_aw_cycles", aw_hi, TMO + 1);
        chk("t3_w_cycles", w_hi, 1);
        chk("t3_err_sticky", err, 1);
        aw_block = 1'b0;

        // short job with source gaps and a toggling sink
        src_gap  = 4'b0110;
        dst_mode = 1;
        new_job(4);
        expect_job(4, 0, 1'b0);
        pulse_start(4);
        wait_done("t4", 200);
        chk("t4_err", err, 0);
        src_gap  = 4'b0000;

        // zero-length start is rejected
        new_job(0);
        pulse_start(0);
        @(negedge axis_clk);
        chk("t5_err", err, 1);
        chk("t5_busy", busy, 0);
        repeat (5) @(negedge axis_clk);
        chk("t5_busy_hold", busy, 0);
        chk("t5_no_aw", aw_hi, 0);

        // cfg_start during RUN is ignored; err cleared by the accepted start
        new_job(8);
        expect_job(8, 0, 1'b0);
        pulse_start(8);
        @(negedge axis_clk);
        chk("t6_err_clr", err, 0);
        for (int i = 0; i < 400 && exp_dst.size() > 5; i++) @(negedge axis_clk);
        if (exp_dst.size() > 5) fail_now("t6_run_wait", exp_dst.size());
        pulse_start(3);
        @(negedge axis_clk);
        chk("t6_busy", busy, 1);
        chk("t6_no_restart", bus.awvalid, 0);
        wait_done("t6", 300);
        repeat (20) @(negedge axis_clk);
        chk("t6_one_done", done_n, 1);
        dst_mode = 0;

        // FIR raises sm_tlast early on the 3rd of 4 outputs
        new_job(4);
        tl_idx = 2;
        expect_job(4, 0, TLAST_ERR[0]);
        pulse_start(4);
        wait_done("t7", 200);
        chk("t7_err", err, TLAST_ERR);

        // reset mid-RUN with the sink stalled
        dst_mode = 2;
        new_job(16);
        expect_job(16, 0, 1'b0);
        pulse_start(16);
        for (int i = 0; i < 400 && exp_ss.size() > 0; i++) @(negedge axis_clk);
        if (exp_ss.size() > 0) fail_now("t8_run_wait", exp_ss.size());
        chk("t8_busy_pre", busy, 1);
        @(negedge axis_clk);
        mon_en = 1'b0;
        #2;
        axis_rst_n = 1'b0;
        #1;
        chk("t8_rst_ctl", ctl_vec(), 0);
        chk("t8_rst_addr", {bus.awaddr, bus.araddr}, 0);
        chk("t8_rst_wdata", bus.wdata, 0);
        exp_aw.delete(); exp_w.delete(); exp_ar.delete();
        exp_ss.delete(); exp_dst.delete(); exp_done.delete();
        dst_mode = 0;
        @(negedge axis_clk);
        axis_rst_n = 1'b1;
        mon_en = 1'b1;

        // recovery job after reset
        new_job(2);
        expect_job(2, 0, 1'b0);
        pulse_start(2);
        wait_done("t9", 200);

        chk("left_aw", exp_aw.size(), 0);
        chk("left_w", exp_w.size(), 0);
        chk("left_ar", exp_ar.size(), 0);
        chk("left_ss", exp_ss.size(), 0);
        chk("left_dst", exp_dst.size(), 0);
        chk("left_done", exp_done.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d checks before time limit", checks);
        $fatal(1, "time limit");
    end
endmodule

// File: doc/fir_job_sequencer.md
Name: fir_job_sequencer

Overview:
Master-side controller that runs one complete FIR job on the fir core without CPU involvement. On a start command it programs the data length over AXI-Lite and sets ap_start. It then gates exactly cfg_len samples from an upstream stream into the FIR and cfg_len results out to a downstream sink. Finally it polls ap_done before signalling completion. It sits between the user-project stream sources/sinks and the fir core's AXI-Lite and AXI-Stream slave ports.

Parameters:
pADDR_WIDTH, 12, AXI-Lite address width
pDATA_WIDTH, 32, AXI-Lite/stream data width
pLEN_WIDTH, 10, job length counter width
pTIMEOUT, 15, max cycles waiting on any single AXI-Lite handshake
pPOLL_MAX, 255, max ap_done poll reads before error

Ports:
axis_clk  in  1  clock
axis_rst_n  in  1  reset; one clock, asynchronous, active-low
cfg_start  in  1  single-cycle job start request
cfg_len  in  pLEN_WIDTH  samples in job; sampled on accepted cfg_start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse on job completion
err  out  1  sticky error; cleared on next accepted start
awvalid/awready  out/in  1  AXI-Lite write address handshake
awaddr  out  pADDR_WIDTH  write address
wvalid/wready  out/in  1  AXI-Lite write data handshake
wdata  out  pDATA_WIDTH  write data
arvalid/arready  out/in  1  AXI-Lite read address handshake
araddr  out  pADDR_WIDTH  read address
rvalid/rready  in/out  1  AXI-Lite read data handshake
rdata  in  pDATA_WIDTH  read data
src_tvalid/src_tready  in/out  1  upstream X[n] handshake
src_tdata  in  pDATA_WIDTH  upstream sample
ss_tvalid/ss_tready  out/in  1  to FIR stream-in
ss_tdata  out  pDATA_WIDTH  = src_tdata
ss_tlast  out  1  last input sample
sm_tvalid/sm_tready  in/out  1  from FIR stream-out
sm_tdata  in  pDATA_WIDTH  FIR result
sm_tlast  in  1  FIR last flag
dst_tvalid/dst_tready  out/in  1  downstream Y[n] handshake
dst_tdata  out  pDATA_WIDTH  = sm_tdata
dst_tlast  out  1  last output sample

Behaviour:
- Reset (async, any state): FSM enters IDLE; counters cleared. All outputs are 0: busy, done, err, all valid/ready, awaddr, wdata, araddr, ss_tlast, dst_tlast.
- FSM states: IDLE, WR_LEN, WR_START, RUN, POLL_AR, POLL_R, DONE.
- IDLE: cfg_start with cfg_len!=0 latches len, clears err, sets busy, enters WR_LEN. cfg_start with cfg_len==0 sets err and stays in IDLE.
- WR_LEN: awaddr=0x10, wdata=len zero-extended. WR_START: awaddr=0x00, wdata=0x1.
- AXI-Lite write rule: awvalid and wvalid rise together. Each drops the cycle after its own handshake. The FSM advances once both handshakes have occurred, in any order or in the same cycle.
- AXI-Lite timeout: if more than pTIMEOUT cycles pass in a write/read state without completion, set err, drop all valids, and go to DONE.
- RUN: in_cnt and out_cnt each run 0..len-1.
  - Input side, while in_cnt<len: ss_tvalid=src_tvalid, src_tready=ss_tready. Otherwise both are 0.
  - ss_tlast=1 when in_cnt==len-1.
  - Output side, while out_cnt<len: dst_tvalid=sm_tvalid, sm_tready=dst_tready. Otherwise both are 0.
  - dst_tlast=1 when out_cnt==len-1.
  - Each counter increments on its own handshake. Input and output run concurrently; same-cycle handshakes both count.
  - Leave RUN when both counters reach len.
- POLL_AR: araddr=0x00, arvalid until arready. POLL_R: rready=1 until rvalid.
  - rdata[1]==1 (ap_done): go to DONE.
  - Otherwise increment poll_cnt and return to POLL_AR after one idle cycle.
  - poll_cnt==pPOLL_MAX: set err and go to DONE.
- DONE: done=1 for one cycle, busy=0 from the next cycle, return to IDLE.
- cfg_start while busy is ignored; the job is not restarted.
- Stream datapaths are combinational pass-through, so data latency is 0 cycles. Control latency is 1 cycle from cfg_start to awvalid.

Optional Feature:
FIR_SEQ_TLAST_CHK_EN
- Defined: on each sm handshake in RUN, compare sm_tlast against (out_cnt==len-1). On mismatch, set err; the job still completes normally.
- Undefined: sm_tlast is ignored and err never reflects tlast mismatch.

Test Plan:
- cfg_len=64, ready sinks, FIR ready, ap_done on first poll -> AW/W writes 0x10=64 then 0x00=1; 64 ss handshakes with ss_tlast on the 64th; 64 dst handshakes with dst_tlast on the 64th; one read of 0x00; done pulse; err=0.
- awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid holds 3 cycles; FSM advances only after both handshakes.
- awready held 0 for 20 cycles -> err=1 after 15 cycles, done pulse, busy=0.
- cfg_len=4, dst_tready toggling and src_tvalid gaps -> exactly 4 in and 4 out, no extra handshakes, src_tready=0 after the 4th input.
- cfg_len=0 start -> err=1, busy stays 0. cfg_start during RUN -> ignored. axis_rst_n low mid-RUN -> all outputs 0 immediately.
- With FIR_SEQ_TLAST_CHK_EN, FIR asserts sm_tlast on the 3rd of 4 outputs -> err=1 and the job still completes with done.
